int_mdu_sched: RTL and testbench

INT_MDU_SCHED -- requirements
Module: int_mdu_sched

---
 rtl/int_mdu_sched.sv | 187 ++++++++++++++++++
 tb/tb_int_mdu_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_mdu_sched.sv
// Issue scheduler for MDU_NUM multiply/divide units shared by REQ_NUM requesters.
// Define MDU_DIVZ_FAST_EN to finish divide-by-zero ops after MUL_LAT cycles.
module int_mdu_sched #(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned MDU_NUM    = 2,
    parameter int unsigned MUL_LAT    = 3,
    parameter int unsigned DIV_CYCLES = 20,
    localparam int unsigned IDX_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_squash_vld,
    input  logic [REQ_NUM-1:0]                i_req_vld,
    input  logic [REQ_NUM-1:0]                i_req_isDiv,
    input  logic [REQ_NUM-1:0]                i_req_divz,
    output logic [REQ_NUM-1:0]                o_req_grant,
    output logic [MDU_NUM-1:0]                o_issue_vld,
    output logic [MDU_NUM-1:0][IDX_W-1:0]     o_issue_reqIdx,
    output logic [MDU_NUM-1:0]                o_issue_isDiv,
    output logic [MDU_NUM-1:0]                o_div_done,
    output logic [MDU_NUM-1:0]                o_unit_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StDivRun,
        StDivDone
    } unit_state_e;

    unit_state_e              state_q [MDU_NUM];
    unit_state_e              state_d [MDU_NUM];
    logic [CNT_W-1:0]         cnt_q   [MDU_NUM];
    logic [CNT_W-1:0]         cnt_d   [MDU_NUM];
    logic [IDX_W-1:0]         rr_q;
    logic [IDX_W-1:0]         rr_d;

    logic                     grant_en;
    logic [MDU_NUM-1:0]       div_ok;
    logic [MDU_NUM-1:0]       mul_ok;
    logic [REQ_NUM-1:0]       grant;
    logic [MDU_NUM-1:0]       unit_taken;
    logic [MDU_NUM-1:0]       issue_div;
    logic [MDU_NUM-1:0][IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0]         last_idx;
    logic                     any_grant;
    int                       scan;
    logic [IDX_W-1:0]         sel;

`ifdef MDU_DIVZ_FAST_EN
    logic [MDU_NUM-1:0]       issue_divz;
`else
    logic                     unused_divz;
    assign unused_divz = ^i_req_divz;
`endif

    assign grant_en = !rst && !i_squash_vld;

    // A mul issued while cnt==MUL_LAT would write back in the divide's done cycle.
    always_comb begin
        div_ok = '0;
        mul_ok = '0;
        for (int u = 0; u < MDU_NUM; u++) begin
            div_ok[u] = (state_q[u] != StDivRun);
            mul_ok[u] = !((state_q[u] == StDivRun) && (cnt_q[u] == CNT_W'(MUL_LAT)));
        end
    end

    // Round-robin scan from rr; each requester takes the lowest free eligible unit.
    always_comb begin
        grant      = '0;
        unit_taken = '0;
        issue_div  = '0;
        issue_idx  = '0;
        last_idx   = rr_q;
        any_grant  = 1'b0;
        scan       = 0;
        sel        = '0;
`ifdef MDU_DIVZ_FAST_EN
        issue_divz = '0;
`endif
        for (int k = 0; k < REQ_NUM; k++) begin
            scan = int'(rr_q) + k;
            if (scan >= int'(REQ_NUM)) begin
                scan = scan - int'(REQ_NUM);
            end
            sel = IDX_W'(scan);
            if (grant_en && i_req_vld[sel]) begin
                for (int u = 0; u < MDU_NUM; u++) begin
                    if (!grant[sel] && !unit_taken[u] &&
                        (i_req_isDiv[sel] ? div_ok[u] : mul_ok[u])) begin
                        grant[sel]    = 1'b1;
                        unit_taken[u] = 1'b1;
                        issue_idx[u]  = sel;
                        issue_div[u]  = i_req_isDiv[sel];
`ifdef MDU_DIVZ_FAST_EN
                        issue_divz[u] = i_req_divz[sel];
`endif
                        last_idx      = sel;
                        any_grant     = 1'b1;
                    end
                end
            end
        end

        if (i_squash_vld) begin
            rr_d = '0;
        end else if (any_grant) begin
            if (int'(last_idx) == int'(REQ_NUM) - 1) begin
                rr_d = '0;
            end else begin
                rr_d = last_idx + IDX_W'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    always_comb begin
        for (int u = 0; u < MDU_NUM; u++) begin
            state_d[u] = state_q[u];
            cnt_d[u]   = cnt_q[u];
            unique case (state_q[u])
                StIdle: ;
                StDivRun: begin
                    if (cnt_q[u] == CNT_W'(1)) begin
                        state_d[u] = StDivDone;
                        cnt_d[u]   = '0;
                    end else begin
                        cnt_d[u] = cnt_q[u] - CNT_W'(1);
                    end
                end
                StDivDone: state_d[u] = StIdle;
                default: begin
                    state_d[u] = StIdle;
                    cnt_d[u]   = '0;
                end
            endcase

            if (unit_taken[u] && issue_div[u]) begin
                state_d[u] = StDivRun;
                cnt_d[u]   = CNT_W'(DIV_CYCLES - 1);
`ifdef MDU_DIVZ_FAST_EN
                if (issue_divz[u]) begin
                    cnt_d[u] = CNT_W'(MUL_LAT - 1);
                end
`endif
            end

            if (i_squash_vld) begin
                state_d[u] = StIdle;
                cnt_d[u]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            for (int u = 0; u < MDU_NUM; u++) begin
                state_q[u] <= StIdle;
                cnt_q[u]   <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int u = 0; u < MDU_NUM; u++) begin
                state_q[u] <= state_d[u];
                cnt_q[u]   <= cnt_d[u];
            end
        end
    end

    always_comb begin
        o_req_grant    = grant;
        o_issue_vld    = unit_taken;
        o_issue_reqIdx = issue_idx;
        o_issue_isDiv  = issue_div;
        o_div_done     = '0;
        o_unit_busy    = '0;
        for (int u = 0; u < MDU_NUM; u++) begin
            o_div_done[u]  = (state_q[u] == StDivDone) && grant_en;
            o_unit_busy[u] = (state_q[u] == StDivRun) && !rst;
        end
    end

endmodule

// File: tb/tb_int_mdu_sched.sv
// Directed bench for int_mdu_sched; divide completions are scoreboarded by expected cycle.
module tb_int_mdu_sched;

    logic            clk = 1'b0;
    logic            rst;
    logic            squash;
    logic [3:0]      vld;
    logic [3:0]      isdiv;
    logic [3:0]      divz;
    logic [3:0]      grant;
    logic [1:0]      ivld;
    logic [1:0][1:0] iidx;
    logic [1:0]      iisdiv;
    logic [1:0]      done;
    logic [1:0]      busy;

    typedef struct {
        int unit;
        int cyc;
    } done_t;

    done_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    g;

`ifdef MDU_DIVZ_FAST_EN
    localparam int DIVZ_LAT = 3;
`else
    localparam int DIVZ_LAT = 20;
`endif

    int_mdu_sched #(
        .REQ_NUM    (4),
        .MDU_NUM    (2),
        .MUL_LAT    (3),
        .DIV_CYCLES (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_squash_vld   (squash),
        .i_req_vld      (vld),
        .i_req_isDiv    (isdiv),
        .i_req_divz     (divz),
        .o_req_grant    (grant),
        .o_issue_vld    (ivld),
        .o_issue_reqIdx (iidx),
        .o_issue_isDiv  (iisdiv),
        .o_div_done     (done),
        .o_unit_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_done(input int unit, input int at);
        done_t e;
        e.unit = unit;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Expected done vector for this cycle comes from the scoreboard; entries are popped.
    task automatic eval();
        logic [1:0] exp_vec;
        @(negedge clk);
        exp_vec = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                exp_vec = exp_vec | (2'b01 << exp_q[i].unit);
                exp_q.delete(i);
            end
        end
        check("div_done", 32'(done), 32'(exp_vec));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            eval();
            tick();
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, 32'({grant, ivld, iidx, iisdiv, done, busy}), 32'h0);
    endtask

    initial begin
        rst    = 1'b1;
        squash = 1'b0;
        vld    = '0;
        isdiv  = '0;
        divz   = '0;

        eval(); check_zero("reset_outputs"); tick();
        eval(); check_zero("reset_outputs_2"); tick();
        rst = 1'b0;
        eval(); check_zero("post_reset_idle"); tick();

        // Four muls, two units: two rounds of grants.
        vld = 4'hf; isdiv = 4'h0;
        eval();
        check("mul_grant_1", 32'(grant), 32'h3);
        check("mul_ivld_1", 32'(ivld), 32'h3);
        check("mul_idx_1", 32'(iidx), 32'h4);
        check("mul_isdiv_1", 32'(iisdiv), 32'h0);
        tick();
        eval();
        check("mul_grant_2", 32'(grant), 32'hc);
        check("mul_ivld_2", 32'(ivld), 32'h3);
        check("mul_idx_2", 32'(iidx), 32'he);
        tick();
        vld = 4'h0;

        // Divs on both units; a third div is held until the units finish.
        g = cyc;
        vld = 4'b0011; isdiv = 4'hf;
        push_done(0, g + 20);
        push_done(1, g + 20);
        eval();
        check("div_grant", 32'(grant), 32'h3);
        check("div_isdiv", 32'(iisdiv), 32'h3);
        tick();
        vld = 4'b0100;
        for (int i = 1; i < 20; i++) begin
            eval();
            check("div_hold_grant", 32'(grant), 32'h0);
            check("div_busy", 32'(busy), 32'h3);
            tick();
        end
        push_done(0, g + 40);
        eval();
        check("div_regrant", 32'(grant), 32'h4);
        check("div_regrant_ivld", 32'(ivld), 32'h1);
        check("div_regrant_idx", 32'(iidx), 32'h2);
        check("div_done_busy", 32'(busy), 32'h0);
        tick();
        vld = 4'h0;
        eval();
        check("div2_busy", 32'(busy), 32'h1);
        tick();
        cycles(19);

        // Writeback collision: mul blocked when both units have cnt==MUL_LAT.
        g = cyc;
        vld = 4'b0011; isdiv = 4'hf;
        push_done(0, g + 20);
        push_done(1, g + 20);
        eval();
        check("coll_div_grant", 32'(grant), 32'h3);
        tick();
        vld = 4'h0;
        cycles(16);
        vld = 4'b1000; isdiv = 4'h0;
        eval();
        check("coll_mul_blocked", 32'(grant), 32'h0);
        tick();
        eval();
        check("coll_mul_grant", 32'(grant), 32'h8);
        check("coll_mul_ivld", 32'(ivld), 32'h1);
        check("coll_mul_idx", 32'(iidx), 32'h3);
        tick();
        vld = 4'h0;
        cycles(2);

        // Squash mid-divide, with a competing mul request in the squash cycle.
        vld = 4'b0001; isdiv = 4'b0001;
        eval();
        check("sq_div_grant", 32'(grant), 32'h1);
        tick();
        vld = 4'h0;
        cycles(4);
        squash = 1'b1; vld = 4'b0010; isdiv = 4'h0;
        eval();
        check("sq_grant", 32'(grant), 32'h0);
        check("sq_ivld", 32'(ivld), 32'h0);
        tick();
        squash = 1'b0; vld = 4'h0;
        eval();
        check("sq_busy", 32'(busy), 32'h0);
        tick();
        cycles(20);
        vld = 4'hf; isdiv = 4'h0;
        eval();
        check("sq_rr_reset", 32'(grant), 32'h3);
        tick();
        vld = 4'h0;

        // Divide by zero: fast path only when enabled.
        g = cyc;
        vld = 4'b0001; isdiv = 4'b0001; divz = 4'b0001;
        push_done(0, g + DIVZ_LAT);
        eval();
        check("divz_grant", 32'(grant), 32'h1);
        tick();
        vld = 4'h0; divz = 4'h0;
        cycles(22);

        // Reset during a divide cancels it.
        vld = 4'b0001; isdiv = 4'b0001;
        eval();
        check("rst_div_grant", 32'(grant), 32'h1);
        tick();
        vld = 4'h0;
        cycles(9);
        rst = 1'b1;
        eval(); check_zero("rst_mid_outputs"); tick();
        rst = 1'b0;
        eval(); check_zero("rst_after_outputs"); tick();
        cycles(15);
        vld = 4'hf; isdiv = 4'h0;
        eval();
        check("rst_rr_reset", 32'(grant), 32'h3);
        tick();
        vld = 4'h0;
        cycles(2);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
